// File: rtl/elevator_car_ctrl.sv
// Elevator car motion controller.
// Reads the floor-call vectors and runs a collective up/down sweep.
// It steps the car one floor at a time, times the door dwell, and pulses
// served_* on each door opening so upstream logic can clear the calls it satisfied.
// Optional build macro DOOR_HOLD_EN adds a door_hold input.
// While door_hold is high, the door dwell timer keeps restarting.
module elevator_car_ctrl #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 16,
  parameter int DOOR_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_inside,
  input  logic [NUM_FLOORS-1:0] call_up,
  input  logic [NUM_FLOORS-1:0] call_down,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  served_valid,
  output logic [FLOOR_W-1:0]    served_floor,
  output logic                  served_inside,
  output logic                  served_up,
  output logic                  served_down
`ifdef DOOR_HOLD_EN
  ,
  input  logic                  door_hold
`endif
);

  localparam int MAX_CYCLES = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TMR_W      = $clog2(MAX_CYCLES);

  localparam logic [TMR_W-1:0]   MOVE_LOAD = TMR_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   DOOR_LOAD = TMR_W'(DOOR_CYCLES - 1);
  localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_ARRIVE,
    ST_DOOR
  } state_t;

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_up_q, dir_up_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               served_valid_q, served_valid_d;
  logic [FLOOR_W-1:0] served_floor_q, served_floor_d;
  logic               served_inside_q, served_inside_d;
  logic               served_up_q, served_up_d;
  logic               served_down_q, served_down_d;

  logic [NUM_FLOORS-1:0] all_calls;
  logic inside_here, up_here, down_here, any_here;
  logic above, below, ahead, behind;
  logic dir_next, stop_here, hold_now;

`ifdef DOOR_HOLD_EN
  assign hold_now = door_hold;
`else
  assign hold_now = 1'b0;
`endif

  // Summarise the call vectors relative to the car's floor and direction.
  always_comb begin
    all_calls   = call_inside | call_up | call_down;
    inside_here = call_inside[floor_q];
    up_here     = call_up[floor_q];
    down_here   = call_down[floor_q];
    any_here    = all_calls[floor_q];
    above       = 1'b0;
    below       = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor_q)) above = above | all_calls[i];
      if (i < int'(floor_q)) below = below | all_calls[i];
    end
    ahead     = dir_up_q ? above : below;
    behind    = dir_up_q ? below : above;
    dir_next  = (ahead | (dir_up_q ? up_here : down_here)) ? dir_up_q : ~dir_up_q;
    stop_here = inside_here | (dir_up_q & up_here) | (~dir_up_q & down_here) |
                (any_here & ~ahead);
  end

  // Sweep FSM: next state, floor stepping, timers and the served pulse.
  always_comb begin
    state_d         = state_q;
    floor_d         = floor_q;
    dir_up_d        = dir_up_q;
    timer_d         = timer_q;
    served_valid_d  = 1'b0;
    served_floor_d  = '0;
    served_inside_d = 1'b0;
    served_up_d     = 1'b0;
    served_down_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_here) begin
          state_d         = ST_DOOR;
          timer_d         = DOOR_LOAD;
          dir_up_d        = dir_next;
          served_valid_d  = 1'b1;
          served_floor_d  = floor_q;
          served_inside_d = inside_here;
          served_up_d     = up_here & dir_next;
          served_down_d   = down_here & ~dir_next;
        end else if (above) begin
          state_d  = ST_MOVE;
          dir_up_d = 1'b1;
          timer_d  = MOVE_LOAD;
        end else if (below) begin
          state_d  = ST_MOVE;
          dir_up_d = 1'b0;
          timer_d  = MOVE_LOAD;
        end
      end

      ST_MOVE: begin
        if (timer_q == '0) begin
          state_d = ST_ARRIVE;
          floor_d = dir_up_q ? (floor_q + FLOOR_ONE) : (floor_q - FLOOR_ONE);
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end

      ST_ARRIVE: begin
        if (stop_here) begin
          state_d         = ST_DOOR;
          timer_d         = DOOR_LOAD;
          dir_up_d        = dir_next;
          served_valid_d  = 1'b1;
          served_floor_d  = floor_q;
          served_inside_d = inside_here;
          served_up_d     = up_here & dir_next;
          served_down_d   = down_here & ~dir_next;
        end else if (ahead) begin
          state_d = ST_MOVE;
          timer_d = MOVE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DOOR: begin
        if (hold_now) begin
          timer_d = DOOR_LOAD;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TMR_ONE;
        end else if (ahead) begin
          state_d = ST_MOVE;
          timer_d = MOVE_LOAD;
        end else if (behind) begin
          state_d  = ST_MOVE;
          dir_up_d = ~dir_up_q;
          timer_d  = MOVE_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset that abandons any move or door cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      floor_q         <= '0;
      dir_up_q        <= 1'b1;
      timer_q         <= '0;
      served_valid_q  <= 1'b0;
      served_floor_q  <= '0;
      served_inside_q <= 1'b0;
      served_up_q     <= 1'b0;
      served_down_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      floor_q         <= floor_d;
      dir_up_q        <= dir_up_d;
      timer_q         <= timer_d;
      served_valid_q  <= served_valid_d;
      served_floor_q  <= served_floor_d;
      served_inside_q <= served_inside_d;
      served_up_q     <= served_up_d;
      served_down_q   <= served_down_d;
    end
  end

  assign floor         = floor_q;
  assign dir_up        = dir_up_q;
  assign moving        = (state_q == ST_MOVE);
  assign door_open     = (state_q == ST_DOOR);
  assign served_valid  = served_valid_q;
  assign served_floor  = served_floor_q;
  assign served_inside = served_inside_q;
  assign served_up     = served_up_q;
  assign served_down   = served_down_q;

endmodule

// File: doc/elevator_car_ctrl.md
Name: elevator_car_ctrl

Overview:
Car motion controller that sits directly downstream of the floor-call register file. It consumes the per-floor call vectors (inside, up, down), decides travel direction with a collective up/down sweep policy, and steps the car floor by floor. It runs the door dwell timer and emits a one-cycle "served" pulse so upstream logic can clear satisfied calls.

Parameters:
NUM_FLOORS, 8, number of floors; call vectors are NUM_FLOORS wide, bit 0 = lowest floor
FLOOR_W, 3, width of floor index, must equal ceil(log2(NUM_FLOORS))
MOVE_CYCLES, 16, clock cycles to travel one floor (>=2)
DOOR_CYCLES, 32, clock cycles the door stays open (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
call_inside  in  NUM_FLOORS  car-button request per floor
call_up  in  NUM_FLOORS  hall up request per floor
call_down  in  NUM_FLOORS  hall down request per floor
floor  out  FLOOR_W  current car floor
dir_up  out  1  current/next travel direction, 1=up, 0=down
moving  out  1  high in MOVE state
door_open  out  1  high in DOOR state
served_valid  out  1  one-cycle pulse on DOOR entry
served_floor  out  FLOOR_W  floor being served, valid with served_valid
served_inside  out  1  inside call at served_floor cleared
served_up  out  1  up hall call at served_floor cleared
served_down  out  1  down hall call at served_floor cleared

Behaviour:
- Clock clk; reset is synchronous, active-high. All state registered on posedge clk.
- Reset values: state=IDLE, floor=0, dir_up=1, moving=0, door_open=0, served_* =0, timers=0. Reset mid-move or mid-door aborts immediately; no served pulse.
- Derived (combinational from inputs): any_here = inside[f]|up[f]|down[f]; above = OR of all three vectors at floors >f; below = same at floors <f.
- IDLE: if any_here -> DOOR; else if above -> dir_up=1, MOVE; else if below -> dir_up=0, MOVE; else stay. above wins over below on tie.
- MOVE: moving=1; counter loads MOVE_CYCLES-1 on entry, decrements each cycle; at 0, floor +=1 (dir_up) or -=1, then ARRIVE.
- ARRIVE (one cycle, moving=0): stop if inside[f], or (dir_up & up[f]), or (!dir_up & down[f]), or (any_here & no calls ahead in dir). Stop -> DOOR; else if calls ahead -> MOVE; else IDLE.
- Floor clamp: never MOVE up from NUM_FLOORS-1 or down from 0; "ahead" is empty at the end floors by construction.
- DOOR entry: compute dir_next: keep dir_up if (calls ahead | hall call at f in dir_up); else reverse. served_valid=1 for exactly the entry cycle with served_floor=f, served_inside=inside[f], served_up=up[f]&dir_next, served_down=down[f]&!dir_next; dir_up<=dir_next.
- DOOR: door_open=1 for exactly DOOR_CYCLES cycles. Calls arriving at f during DOOR are not re-served until the next stop. At expiry: calls ahead in dir_up -> MOVE; else calls behind -> flip dir_up, MOVE; else IDLE.
- Inputs change only calls; controller never clears them directly.
- Latency: IDLE with call k floors away -> door_open after 1 + k*(MOVE_CYCLES+1) cycles.

Optional Feature:
DOOR_HOLD_EN: when defined, adds input door_hold (1 bit). In DOOR, door_hold=1 reloads the dwell timer to DOOR_CYCLES-1 each cycle. This extends door_open until door_hold is low for DOOR_CYCLES consecutive cycles, and never re-pulses served_valid. When undefined, the port does not exist and dwell is fixed at DOOR_CYCLES.

Test Plan:
(MOVE_CYCLES=4, DOOR_CYCLES=8)
- Reset, no calls for 50 cycles -> floor=0, dir_up=1, moving=0, door_open=0, served_valid never high.
- At floor 0 IDLE, call_inside=8'h08 -> moving 3 floors, door_open rises 16 cycles after call, served_valid 1 cycle with served_floor=3, served_inside=1.
- Car moving up from 1 toward 6 (inside[6]), call_down[4]=1 and call_up[4]=1 -> stops at 4 with served_up=1, served_down=0; continues to 6.
- Car at 5, dir_up=1, only call_down[2] -> ARRIVE logic reverses; door at 2 with served_down=1, dir_up=0.
- Call at current floor 0 while IDLE -> DOOR next cycle, door_open high exactly 8 cycles, then IDLE.
- Assert reset during MOVE between floors 2 and 3 -> next cycle floor=0, moving=0, IDLE; with DOOR_HOLD_EN, door_hold held 20 cycles keeps door_open for 20+8 cycles.
